// File: rtl/systolic_pkg.sv
// Shared state encoding and default ibus address map for the systolic array sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      KICK,
      POLL,
      DRAIN,
      DONE
   } seq_state_t;

   localparam logic [15:0] DEF_LOAD_BASE = 16'h0000;
   localparam logic [15:0] DEF_RES_BASE  = 16'h0100;
   localparam logic [15:0] DEF_CTRL_ADR  = 16'h0200;
   localparam logic [15:0] DEF_STAT_ADR  = 16'h0201;
   localparam logic [15:0] CMD_START     = 16'h0001;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_rd_fifo.sv
// Small result buffer between the ibus read path and the backpressured output stream.
module seq_rd_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 16,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty    = (count == '0);
      full     = (count == CW'(DEPTH));
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      pop_data = mem[rd_ptr];
   end

   // Pointers wrap explicitly so non power-of-two depths behave.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Runs one job on the 4x4 systolic array: load operands, kick, poll status, drain results.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int          N_LOAD     = 32,
   parameter int          N_RES      = 16,
   parameter logic [15:0] LOAD_BASE  = DEF_LOAD_BASE,
   parameter logic [15:0] RES_BASE   = DEF_RES_BASE,
   parameter logic [15:0] CTRL_ADR   = DEF_CTRL_ADR,
   parameter logic [15:0] STAT_ADR   = DEF_STAT_ADR,
   parameter int          RD_LAT     = 1,
   parameter int          TIMEOUT    = 1024,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_start,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        ren,
   output logic [15:0] ibus_radr,
   input  logic [15:0] ibus_rdata,
   output logic        wen,
   output logic [15:0] ibus_wadr,
   output logic [15:0] ibus_wdata
);

   localparam int IDX_W = $clog2(max_int(N_LOAD, N_RES) + 1);
   localparam int PC_W  = $clog2(TIMEOUT + 1);
   localparam int CW    = $clog2(FIFO_DEPTH + 1);
   localparam int SW    = CW + 1;

   seq_state_t        state;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  pop_cnt;
   logic [PC_W-1:0]   poll_cnt;
   logic              poll_pending;
   logic [CW-1:0]     in_flight;
   logic [RD_LAT-1:0] rd_pipe;
   logic              rd_valid;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic              can_issue;

   seq_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (ibus_rdata),
      .pop       (pop),
      .pop_data  (out_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // Reads are admitted only while buffered plus in-flight words still fit the FIFO.
   always_comb begin
      rd_valid  = rd_pipe[RD_LAT-1];
      push      = rd_valid && (state == DRAIN);
      out_valid = !fifo_empty;
      pop       = out_valid && out_ready;
      can_issue = (state == DRAIN) && (idx < IDX_W'(N_RES)) &&
                  (({1'b0, fifo_count} + {1'b0, in_flight}) < SW'(FIFO_DEPTH));
      done      = (state == DRAIN) && pop && (pop_cnt == IDX_W'(N_RES - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= ren;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         err          <= 1'b0;
         in_ready     <= 1'b0;
         ren          <= 1'b0;
         ibus_radr    <= '0;
         wen          <= 1'b0;
         ibus_wadr    <= '0;
         ibus_wdata   <= '0;
         idx          <= '0;
         pop_cnt      <= '0;
         poll_cnt     <= '0;
         poll_pending <= 1'b0;
         in_flight    <= '0;
      end else begin
         ren <= 1'b0;
         wen <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_start) begin
                  err          <= 1'b0;
                  busy         <= 1'b1;
                  in_ready     <= 1'b1;
                  idx          <= '0;
                  pop_cnt      <= '0;
                  poll_cnt     <= '0;
                  poll_pending <= 1'b0;
                  in_flight    <= '0;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               if (in_valid && in_ready) begin
                  wen        <= 1'b1;
                  ibus_wadr  <= LOAD_BASE + 16'(idx);
                  ibus_wdata <= in_data;
                  if (idx == IDX_W'(N_LOAD - 1)) begin
                     idx      <= '0;
                     in_ready <= 1'b0;
                     state    <= KICK;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            KICK: begin
               wen        <= 1'b1;
               ibus_wadr  <= CTRL_ADR;
               ibus_wdata <= CMD_START;
               state      <= POLL;
            end
            POLL: begin
               if (!poll_pending) begin
                  ren          <= 1'b1;
                  ibus_radr    <= STAT_ADR;
                  poll_pending <= 1'b1;
               end else if (rd_valid) begin
                  if (ibus_rdata[0]) begin
                     poll_pending <= 1'b0;
                     state        <= DRAIN;
                  end else if (poll_cnt == PC_W'(TIMEOUT - 1)) begin
                     poll_pending <= 1'b0;
                     err          <= 1'b1;
                     busy         <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     poll_cnt  <= poll_cnt + 1'b1;
                     ren       <= 1'b1;
                     ibus_radr <= STAT_ADR;
                  end
               end
            end
            DRAIN: begin
               if (can_issue) begin
                  ren       <= 1'b1;
                  ibus_radr <= RES_BASE + 16'(idx);
                  idx       <= idx + 1'b1;
               end
               in_flight <= in_flight + CW'(can_issue) - CW'(push);
               if (pop) begin
                  pop_cnt <= pop_cnt + 1'b1;
                  if (pop_cnt == IDX_W'(N_RES - 1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: directed jobs, ibus memory model, decoupled monitor.
module tb_systolic_seq_ctrl;

   localparam int TIMEOUT_TB = 8;
   localparam int FIFO_D     = 4;
   localparam int NL         = 32;
   localparam int NR         = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_start = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        ren;
   logic [15:0] ibus_radr;
   logic [15:0] ibus_rdata = '0;
   logic        wen;
   logic [15:0] ibus_wadr;
   logic [15:0] ibus_wdata;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_wr[$];
   logic [15:0] exp_rd[$];
   logic [16:0] exp_out[$];

   int          stat_zeros = 0;
   bit          stat_stuck = 1'b0;
   int          stat_reads = 0;
   int          res_reads = 0;
   int          pops = 0;
   int          max_outstanding = 0;
   int          done_cnt = 0;
   logic [3:0]  job_id = '0;
   bit          resp_pending = 1'b0;
   logic [15:0] resp_data = '0;

   systolic_seq_ctrl #(
      .TIMEOUT    (TIMEOUT_TB),
      .FIFO_DEPTH (FIFO_D)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_start  (cmd_start),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .ren        (ren),
      .ibus_radr  (ibus_radr),
      .ibus_rdata (ibus_rdata),
      .wen        (wen),
      .ibus_wadr  (ibus_wadr),
      .ibus_wdata (ibus_wdata)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: event seen or bound expired, not expected", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model (RD_LAT = 1) and scoreboard monitor, both sampled mid-cycle.
   always @(negedge clk) begin
      logic [31:0] ew;
      logic [15:0] er;
      logic [16:0] eo;
      if (!rst_n) begin
         resp_pending = 1'b0;
      end else begin
         if (resp_pending) ibus_rdata = resp_data;
         resp_pending = 1'b0;
         if (ren) begin
            if (ibus_radr == 16'h0201) begin
               stat_reads++;
               resp_data = (!stat_stuck && stat_reads > stat_zeros) ? 16'h00F1 : 16'h00F0;
            end else begin
               res_reads++;
               resp_data = {4'hC, job_id, ibus_radr[7:0]};
            end
            resp_pending = 1'b1;
            if (exp_rd.size() == 0) begin
               fail_now("unexpected_read");
            end else begin
               er = exp_rd.pop_front();
               check_output("read_addr", {16'h0, ibus_radr}, {16'h0, er});
            end
         end
         if (wen) begin
            check_output("ren_wen_exclusive", {31'h0, ren}, 32'h0);
            if (exp_wr.size() == 0) begin
               fail_now("unexpected_write");
            end else begin
               ew = exp_wr.pop_front();
               check_output("write_addr_data", {ibus_wadr, ibus_wdata}, ew);
            end
         end
         if (out_valid && out_ready) begin
            pops++;
            if (exp_out.size() == 0) begin
               fail_now("unexpected_out_word");
            end else begin
               eo = exp_out.pop_front();
               check_output("out_data", {16'h0, out_data}, {16'h0, eo[15:0]});
               check_output("done_on_last", {31'h0, done}, {31'h0, eo[16]});
            end
         end else if (done) begin
            fail_now("done_without_pop");
         end
         if (done) done_cnt++;
         if (res_reads - pops > max_outstanding) max_outstanding = res_reads - pops;
      end
   end

   task automatic apply_stimulus(input int zeros, input bit stuck, input int gap, input bit stall,
                                 input bit poke, input bit abort, input logic [15:0] dbase);
      int cyc;
      int n_stat;
      job_id          = job_id + 1'b1;
      stat_zeros      = zeros;
      stat_stuck      = stuck;
      stat_reads      = 0;
      res_reads       = 0;
      pops            = 0;
      max_outstanding = 0;
      done_cnt        = 0;
      for (int i = 0; i < NL; i++) exp_wr.push_back({16'(i), dbase + 16'(i)});
      exp_wr.push_back({16'h0200, 16'h0001});
      n_stat = stuck ? TIMEOUT_TB : zeros + 1;
      for (int i = 0; i < n_stat; i++) exp_rd.push_back(16'h0201);
      if (!stuck) begin
         for (int i = 0; i < NR; i++) begin
            exp_rd.push_back(16'h0100 + 16'(i));
            exp_out.push_back({(i == NR - 1), 4'hC, job_id, 8'(i)});
         end
      end
      if (gap > 0) begin
         in_valid = 1'b1;
         in_data  = 16'hDEAD;
         repeat (3) step();
         in_valid = 1'b0;
      end
      out_ready = !stall;
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      step();
      check_output("err_after_start", {31'h0, err}, 32'h0);
      for (int i = 0; i < NL; i++) begin
         in_valid = 1'b1;
         in_data  = dbase + 16'(i);
         cyc = 0;
         while (!in_ready && cyc < 100) begin
            step();
            cyc++;
         end
         if (cyc >= 100) fail_now("in_ready_timeout");
         step();
         in_valid = 1'b0;
         repeat (gap) step();
      end
      in_valid = 1'b0;
      if (poke) begin
         cmd_start = 1'b1;
         repeat (2) step();
         cmd_start = 1'b0;
         check_output("busy_during_poke", {31'h0, busy}, 32'h1);
      end
      if (stall) begin
         cyc = 0;
         while (res_reads == 0 && cyc < 300) begin
            step();
            cyc++;
         end
         if (cyc >= 300) fail_now("drain_start_timeout");
         if (abort) begin
            step();
            rst_n = 1'b0;
            #1;
            check_output("reset_async_outputs", {25'h0, busy, ren, wen, out_valid, in_ready, done, err}, 32'h0);
            exp_wr.delete();
            exp_rd.delete();
            exp_out.delete();
            out_ready = 1'b1;
            repeat (3) step();
            rst_n = 1'b1;
            step();
            return;
         end
         repeat (20) step();
         check_output("stall_reads_capped", res_reads, FIFO_D);
         out_ready = 1'b1;
      end
      cyc = 0;
      while (busy && cyc < 3000) begin
         step();
         cyc++;
      end
      if (cyc >= 3000) fail_now("job_end_timeout");
      repeat (2) step();
      check_output("done_pulses", done_cnt, stuck ? 0 : 1);
      check_output("err_end", {31'h0, err}, {31'h0, stuck});
      check_output("busy_end", {31'h0, busy}, 32'h0);
      check_output("writes_left", exp_wr.size(), 0);
      check_output("reads_left", exp_rd.size(), 0);
      check_output("out_left", exp_out.size(), 0);
      check_output("poll_reads", stat_reads, n_stat);
      if (!stuck) check_output("outstanding_bound", {31'h0, (max_outstanding <= FIFO_D)}, 32'h1);
      else check_output("no_result_reads", res_reads, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      check_output("reset_outputs", {25'h0, busy, ren, wen, out_valid, in_ready, done, err}, 32'h0);
      rst_n = 1'b1;
      step();
      apply_stimulus(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
      apply_stimulus(3, 1'b0, 0, 1'b0, 1'b1, 1'b0, 16'h2000);
      apply_stimulus(0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 16'h3000);
      apply_stimulus(0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'h4000);
      apply_stimulus(1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 16'h5000);
      apply_stimulus(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16'h6000);
      apply_stimulus(2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h7000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
